// File: rtl/relogio.sv
// 24-hour BCD real-time clock with prescaler and six active-low seven-segment outputs.
// Define RELOGIO_12H_EN for 12-hour mode (hours 12, 01..11, reset 12:00:00).
module relogio #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       KEY,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

`ifdef RELOGIO_12H_EN
    localparam logic [3:0] HT_RST = 4'd1;
    localparam logic [3:0] HU_RST = 4'd2;
`else
    localparam logic [3:0] HT_RST = 4'd0;
    localparam logic [3:0] HU_RST = 4'd0;
`endif

    logic [PW-1:0] r_presc;
    logic [3:0]    r_su, r_st, r_mu, r_mt, r_hu, r_ht;
    logic [3:0]    w_su, w_st, w_mu, w_mt, w_hu, w_ht;
    logic          w_tick, w_c1, w_c2, w_c3, w_c4;

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_c1   = w_tick && (r_su == 4'd9);
    assign w_c2   = w_c1   && (r_st == 4'd5);
    assign w_c3   = w_c2   && (r_mu == 4'd9);
    assign w_c4   = w_c3   && (r_mt == 4'd5);

    always_comb begin
        w_su = r_su;
        w_st = r_st;
        w_mu = r_mu;
        w_mt = r_mt;
        w_hu = r_hu;
        w_ht = r_ht;
        if (w_tick) w_su = (r_su == 4'd9) ? '0 : r_su + 4'd1;
        if (w_c1)   w_st = (r_st == 4'd5) ? '0 : r_st + 4'd1;
        if (w_c2)   w_mu = (r_mu == 4'd9) ? '0 : r_mu + 4'd1;
        if (w_c3)   w_mt = (r_mt == 4'd5) ? '0 : r_mt + 4'd1;
        if (w_c4) begin
`ifdef RELOGIO_12H_EN
            if (r_ht == 4'd1 && r_hu == 4'd2) begin
                w_ht = 4'd0;
                w_hu = 4'd1;
            end
`else
            if (r_ht == 4'd2 && r_hu == 4'd3) begin
                w_ht = 4'd0;
                w_hu = 4'd0;
            end
`endif
            else if (r_hu == 4'd9) begin
                w_ht = r_ht + 4'd1;
                w_hu = '0;
            end else begin
                w_hu = r_hu + 4'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (KEY) begin
            r_presc <= '0;
            r_su    <= '0;
            r_st    <= '0;
            r_mu    <= '0;
            r_mt    <= '0;
            r_hu    <= HU_RST;
            r_ht    <= HT_RST;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_su    <= w_su;
            r_st    <= w_st;
            r_mu    <= w_mu;
            r_mt    <= w_mt;
            r_hu    <= w_hu;
            r_ht    <= w_ht;
        end
    end

    // Active-low segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign HEX0 = seg7(r_su);
    assign HEX1 = seg7(r_st);
    assign HEX2 = seg7(r_mu);
    assign HEX3 = seg7(r_mt);
    assign HEX4 = seg7(r_hu);
    assign HEX5 = seg7(r_ht);

endmodule

// File: tb/tb_relogio.sv
// Directed bench for relogio: one instance with CLK_DIV=4 (prescale/reset timing)
// and one with CLK_DIV=1 (carry chain and day wrap), default 24-hour build.
module tb_relogio;

    logic       clk;
    logic       key4, key1;
    logic [6:0] a0, a1, a2, a3, a4, a5;
    logic [6:0] b0, b1, b2, b3, b4, b5;
    int         checks;
    int         errors;

    relogio #(.CLK_DIV(4)) u4 (
        .CLOCK_50(clk), .KEY(key4),
        .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3), .HEX4(a4), .HEX5(a5)
    );

    relogio #(.CLK_DIV(1)) u1 (
        .CLOCK_50(clk), .KEY(key1),
        .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       seg = 7'h40;
            1:       seg = 7'h79;
            2:       seg = 7'h24;
            3:       seg = 7'h30;
            4:       seg = 7'h19;
            5:       seg = 7'h12;
            6:       seg = 7'h02;
            7:       seg = 7'h78;
            8:       seg = 7'h00;
            9:       seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare a full display against elapsed seconds since midnight.
    task automatic chk_time(input string tag, input int t,
                            input logic [6:0] h5, input logic [6:0] h4, input logic [6:0] h3,
                            input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
        int hh, mm, ss;
        hh = (t / 3600) % 24;
        mm = (t / 60) % 60;
        ss = t % 60;
        chk({tag, ".HEX5"}, h5, seg(hh / 10));
        chk({tag, ".HEX4"}, h4, seg(hh % 10));
        chk({tag, ".HEX3"}, h3, seg(mm / 10));
        chk({tag, ".HEX2"}, h2, seg(mm % 10));
        chk({tag, ".HEX1"}, h1, seg(ss / 10));
        chk({tag, ".HEX0"}, h0, seg(ss % 10));
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        key4 = 1'b1;
        key1 = 1'b1;
        adv(3);
        chk_time("rst4", 0, a5, a4, a3, a2, a1, a0);
        chk_time("rst1", 0, b5, b4, b3, b2, b1, b0);

        key4 = 1'b0;
        key1 = 1'b0;
        adv(3);
        chk_time("div4_e3", 0, a5, a4, a3, a2, a1, a0);
        chk_time("div1_e3", 3, b5, b4, b3, b2, b1, b0);
        adv(1);
        chk("div4_e4", a0, 7'h79);
        adv(3);
        chk("div4_e7", a0, 7'h79);
        adv(1);
        chk("div4_e8", a0, 7'h24);

        // One-cycle reset mid-count, then full prescale delay again.
        key4 = 1'b1;
        adv(1);
        key4 = 1'b0;
        chk_time("midrst4", 0, a5, a4, a3, a2, a1, a0);
        adv(3);
        chk("div4_r3", a0, 7'h40);
        adv(1);
        chk("div4_r4", a0, 7'h79);

        // Reset landing exactly on a tick edge suppresses the increment.
        adv(3);
        key4 = 1'b1;
        adv(1);
        key4 = 1'b0;
        chk_time("tickrst4", 0, a5, a4, a3, a2, a1, a0);
        adv(4);
        chk_time("tickrst4_after", 1, a5, a4, a3, a2, a1, a0);

        // u1 has seen 21 edges since release.
        chk_time("div1_e21", 21, b5, b4, b3, b2, b1, b0);
        adv(616);
        chk_time("t_00_10_37", 637, b5, b4, b3, b2, b1, b0);
        key1 = 1'b1;
        adv(1);
        key1 = 1'b0;
        chk_time("midrst1", 0, b5, b4, b3, b2, b1, b0);

        adv(10);
        chk_time("t10", 10, b5, b4, b3, b2, b1, b0);
        adv(50);
        chk_time("t60", 60, b5, b4, b3, b2, b1, b0);
        adv(540);
        chk_time("t600", 600, b5, b4, b3, b2, b1, b0);
        adv(3000);
        chk_time("t3600", 3600, b5, b4, b3, b2, b1, b0);
        adv(32400);
        chk_time("t36000", 36000, b5, b4, b3, b2, b1, b0);
        adv(50399);
        chk_time("t23_59_59", 86399, b5, b4, b3, b2, b1, b0);
        chk("t23_59_59.h5lit", b5, 7'h24);
        chk("t23_59_59.h4lit", b4, 7'h30);
        adv(1);
        chk_time("wrap", 0, b5, b4, b3, b2, b1, b0);
        adv(1);
        chk_time("wrap+1", 1, b5, b4, b3, b2, b1, b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
